// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: sequences a WIDTH-bit add through one external 4-bit
// CLA slice, least-significant nibble first, chaining carry in a register.
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;

  logic             in_run;
  logic             last_nibble;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;

  assign in_run      = (state_q == S_RUN);
  assign last_nibble = (idx_q == IDXW'(NIBBLES - 1));

  // Select the active nibble by shifting rather than part-selecting, so the
  // index never addresses past the operand when NIBBLES is 1.
  assign a_shift = a_q >> {idx_q, 2'b00};
  assign b_shift = b_q >> {idx_q, 2'b00};

  assign add_a   = in_run ? a_shift[3:0] : 4'd0;
  assign add_b   = in_run ? b_shift[3:0] : 4'd0;
  assign add_cin = in_run ? carry_q : 1'b0;

  // Working sum: the slice result lands in the nibble addressed by idx.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum
    assign sum_d[4*gi +: 4] = (in_run && (idx_q == IDXW'(gi))) ? add_sum
                                                                : sum_q[4*gi +: 4];
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

  // Next-state logic: capture on request, step one nibble per RUN cycle,
  // publish the result on the last nibble and hold it until consumed.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d = add_cout;
        if (last_nibble) begin
          idx_d      = '0;
          rsp_sum_d  = sum_d;
          rsp_cout_d = add_cout;
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and data registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: a 4-nibble and a 1-nibble instance, each
// driving a behavioural 4-bit adder slice, checked against plain arithmetic.
module tb_cla_nibble_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-nibble instance
  logic        req_valid4, req_ready4, op_cin4, add_cin4, add_cout4;
  logic [15:0] op_a4, op_b4, rsp_sum4;
  logic [3:0]  add_a4, add_b4, add_sum4;
  logic        rsp_valid4, rsp_ready4, rsp_cout4, busy4;

  // 1-nibble instance
  logic        req_valid1, req_ready1, op_cin1, add_cin1, add_cout1;
  logic [3:0]  op_a1, op_b1, rsp_sum1;
  logic [3:0]  add_a1, add_b1, add_sum1;
  logic        rsp_valid1, rsp_ready1, rsp_cout1, busy1;

  assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);
  assign {add_cout1, add_sum1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

  cla_nibble_sequencer #(.NIBBLES(4)) u4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .op_a(op_a4), .op_b(op_b4), .op_cin(op_cin4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_sum(rsp_sum4), .rsp_cout(rsp_cout4), .busy(busy4)
  );

  cla_nibble_sequencer #(.NIBBLES(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Carry entering nibble k of a+b+cin, from whole-number arithmetic.
  function automatic logic carry_into(input int unsigned a, input int unsigned b,
                                      input int unsigned cin, input int k);
    int unsigned mask;
    mask = (32'd1 << (4 * k)) - 32'd1;
    return 1'(((a & mask) + (b & mask) + cin) >> (4 * k));
  endfunction

  // One full transaction on the 4-nibble instance. hold = cycles of
  // rsp_ready=0 in DONE; intrude = pulse a foreign request during RUN.
  task automatic txn4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input int hold, input bit intrude);
    logic [16:0] expv;
    expv = 17'(a) + 17'(b) + 17'(cin);
    chk("t4_req_ready_idle", 32'(req_ready4), 32'd1);
    op_a4 = a; op_b4 = b; op_cin4 = cin; req_valid4 = 1'b1;
    tick();
    req_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (intrude && k == 1) begin
        req_valid4 = 1'b1; op_a4 = 16'hAAAA;
      end
      if (intrude && k == 2) begin
        req_valid4 = 1'b0; op_a4 = a;
      end
      chk("t4_run_add_a", 32'(add_a4), 32'((a >> (4 * k)) & 16'hF));
      chk("t4_run_add_b", 32'(add_b4), 32'((b >> (4 * k)) & 16'hF));
      chk("t4_run_add_cin", 32'(add_cin4), 32'(carry_into(32'(a), 32'(b), 32'(cin), k)));
      chk("t4_run_flags", {29'd0, req_ready4, rsp_valid4, busy4}, 32'b001);
      tick();
    end
    req_valid4 = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      chk("t4_done_flags", {29'd0, req_ready4, rsp_valid4, busy4}, 32'b011);
      chk("t4_sum", 32'(rsp_sum4), 32'(expv[15:0]));
      chk("t4_cout", 32'(rsp_cout4), 32'(expv[16]));
      chk("t4_add_idle", {23'd0, add_a4, add_b4, add_cin4}, 32'd0);
      if (h < hold) tick();
    end
    rsp_ready4 = 1'b1;
    tick();
    rsp_ready4 = 1'b0;
    chk("t4_back_idle", {29'd0, req_ready4, rsp_valid4, busy4}, 32'b100);
    chk("t4_sum_kept", 32'(rsp_sum4), 32'(expv[15:0]));
    chk("t4_cout_kept", 32'(rsp_cout4), 32'(expv[16]));
  endtask

  // One transaction on the 1-nibble instance.
  task automatic txn1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] expv;
    expv = 5'(a) + 5'(b) + 5'(cin);
    chk("t1_req_ready_idle", 32'(req_ready1), 32'd1);
    op_a1 = a; op_b1 = b; op_cin1 = cin; req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    chk("t1_run_add", {23'd0, add_a1, add_b1, add_cin1}, {23'd0, a, b, cin});
    chk("t1_run_flags", {29'd0, req_ready1, rsp_valid1, busy1}, 32'b001);
    tick();
    chk("t1_done_flags", {29'd0, req_ready1, rsp_valid1, busy1}, 32'b011);
    chk("t1_sum", 32'(rsp_sum1), 32'(expv[3:0]));
    chk("t1_cout", 32'(rsp_cout1), 32'(expv[4]));
    rsp_ready1 = 1'b1;
    tick();
    rsp_ready1 = 1'b0;
    chk("t1_back_idle", {29'd0, req_ready1, rsp_valid1, busy1}, 32'b100);
  endtask

  initial begin
    reset = 1'b1;
    req_valid4 = 1'b0; op_a4 = '0; op_b4 = '0; op_cin4 = 1'b0; rsp_ready4 = 1'b0;
    req_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; op_cin1 = 1'b0; rsp_ready1 = 1'b0;
    tick();
    tick();
    chk("rst4_flags", {29'd0, req_ready4, rsp_valid4, busy4}, 32'b100);
    chk("rst4_add", {23'd0, add_a4, add_b4, add_cin4}, 32'd0);
    chk("rst4_rsp", {15'd0, rsp_cout4, rsp_sum4}, 32'd0);
    chk("rst1_flags", {29'd0, req_ready1, rsp_valid1, busy1}, 32'b100);
    chk("rst1_rsp", {27'd0, rsp_cout1, rsp_sum1}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed cases
    txn4(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    txn4(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    txn4(16'h8001, 16'h7FFF, 1'b1, 3, 1'b0);
    txn4(16'h0F0F, 16'h0101, 1'b0, 0, 1'b1);

    // Reset during the second RUN cycle
    op_a4 = 16'h1234; op_b4 = 16'h5678; op_cin4 = 1'b0; req_valid4 = 1'b1;
    tick();
    req_valid4 = 1'b0;
    tick();
    chk("mid_rst_busy_before", 32'(busy4), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_flags", {29'd0, req_ready4, rsp_valid4, busy4}, 32'b100);
    chk("mid_rst_add", {23'd0, add_a4, add_b4, add_cin4}, 32'd0);
    chk("mid_rst_rsp", {15'd0, rsp_cout4, rsp_sum4}, 32'd0);
    txn4(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

    txn1(4'hF, 4'h0, 1'b1);
    txn1(4'h7, 4'h8, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 20; i++) begin
      txn4(16'($urandom), 16'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)), 1'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      txn1(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
